odev_uart_tx: RTL and testbench

Serial transmit peripheral for the Hummingbird 8-bit CPU's memory-mapped output-device port. Bytes the CPU stores to the odev slot are queued in a small FIFO, then shifted out on `txd` as 8N1 frames. A status byte goes back to the CPU through the idev input latch, so software can poll for space and idle. The block runs on the CPU clock and needs no handshake beyond the decoded, active-low write strobe.

---
 rtl/odev_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_odev_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/odev_uart_tx.sv
// odev_uart_tx: CPU output-device UART transmitter.
// Stores from the CPU are queued in a small circular FIFO and shifted out
// as 8N1 frames on txd. A registered status byte reports full/empty/active
// and the occupancy count for software polling.
module odev_uart_tx #(
  parameter int CLKS_PER_BIT = 16,  // >= 2
  parameter int FIFO_DEPTH   = 4    // 2, 4, 8 or 16
) (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic       wr_bar,
  input  logic [7:0] din,
  output logic [7:0] status,
  output logic       txd,
  output logic       busy,
  output logic       ovf
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic [7:0]          status_q, status_d;

  logic full, empty, wr_acc, baud_last, pop;

  // Fullness is judged on the pre-edge count, so a write into a full FIFO
  // is dropped even if a pop happens on the same edge.
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign wr_acc    = !wr_bar && !full;
  assign baud_last = (baud_q == BAUD_LAST);

  // State register plus FIFO and output registers; reset flushes everything.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      mem_q    <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      status_q <= 8'h40;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      status_q <= status_d;
    end
  end

  // Next-state logic for the frame sequencer. Pops use the pre-edge empty
  // flag, so a byte written this edge cannot be popped until the next one.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[head_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle bit.
            pop     = 1'b1;
            shift_d = mem_q[head_q];
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy, sticky overflow and the registered poll word.
  always_comb begin
    mem_d  = mem_q;
    tail_d = tail_q;
    head_d = head_q;
    ovf_d  = ovf_q;
    if (!wr_bar) begin
      if (!full) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PTR_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
    busy_d   = (state_d != S_IDLE) || (count_d != '0);
    status_d = {(count_d == CNT_FULL), (count_d == '0), (state_d != S_IDLE),
                5'(count_d)};
  end

  // Line driver: only START and DATA pull the line away from mark.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign status = status_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_odev_uart_tx.sv
// Bench for odev_uart_tx: bytes are pushed to a scoreboard as they are
// written, and a line monitor decodes each txd frame and pops/compares.
module tb_odev_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_bar;
  logic       wr_bar;
  logic [7:0] din;
  logic [7:0] status;
  logic       txd, busy, ovf;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  int         gaps[$];
  logic [7:0] stats[$];

  bit         mon_busy = 1'b0;
  bit         mon_bad;
  logic [7:0] mon_data;
  int         mon_cyc, mon_idx, mon_pos;
  int         cyc = 0;
  int         last_end = 0;

  odev_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_bar(rst_bar), .wr_bar(wr_bar), .din(din),
    .status(status), .txd(txd), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Caller sits at a negedge; strobe covers exactly one rising edge.
  task automatic put(input logic [7:0] b, input bit acc);
    wr_bar = 1'b0;
    din    = b;
    if (acc) sb.push_back(b);
    @(negedge clk);
    wr_bar = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_busy || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: checks every cycle of every bit, records gap/status at start.
  always @(negedge clk) begin
    cyc++;
    if (!rst_bar) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 1;
        mon_bad  = 1'b0;
        mon_data = '0;
        gaps.push_back(cyc - last_end - 1);
        stats.push_back(status);
      end
    end else begin
      mon_idx = mon_cyc / CPB;
      mon_pos = mon_cyc % CPB;
      if (mon_idx == 0) begin
        if (txd !== 1'b0) mon_bad = 1'b1;
      end else if (mon_idx <= 8) begin
        if (mon_pos == 0) mon_data[mon_idx-1] = txd;
        else if (txd !== mon_data[mon_idx-1]) mon_bad = 1'b1;
      end else begin
        if (txd !== 1'b1) mon_bad = 1'b1;
      end
      mon_cyc++;
      if (mon_cyc == 10 * CPB) begin
        mon_busy = 1'b0;
        last_end = cyc;
        chk("frame_format", mon_bad, 0);
        if (sb.size() == 0) chk("frame_unexpected_sb_len", sb.size(), 1);
        else chk("frame_data", mon_data, sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_bar = 1'b1;
    wr_bar  = 1'b1;
    din     = 8'h00;
    #2 rst_bar = 1'b0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_status", status, 8'h40);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_bar = 1'b1;
    @(negedge clk);

    // Single byte
    gaps.delete(); stats.delete();
    put(8'hA5, 1);
    chk("single_status_after_wr", status, 8'h01);
    chk("single_busy_after_wr", busy, 1);
    chk("single_txd_idle", txd, 1);
    @(negedge clk);
    chk("single_txd_start", txd, 0);
    chk("single_status_after_pop", status, 8'h60);
    repeat (39) @(negedge clk);
    chk("single_busy_p39", busy, 1);
    @(negedge clk);
    chk("single_busy_p40", busy, 0);
    chk("single_status_end", status, 8'h40);
    wait_drain(200);

    // Back-to-back
    gaps.delete(); stats.delete();
    put(8'h01, 1);
    put(8'h80, 1);
    put(8'hFF, 1);
    wait_drain(400);
    chk("b2b_frames", stats.size(), 3);
    if (stats.size() == 3) begin
      chk("b2b_stat_pop1", stats[0], 8'h21);
      chk("b2b_stat_pop2", stats[1], 8'h21);
      chk("b2b_stat_pop3", stats[2], 8'h60);
      chk("b2b_gap2", gaps[1], 0);
      chk("b2b_gap3", gaps[2], 0);
    end

    // Overflow
    gaps.delete(); stats.delete();
    put(8'h11, 1);
    put(8'h22, 1);
    put(8'h33, 1);
    put(8'h44, 1);
    put(8'h55, 1);
    chk("ovf_not_yet", ovf, 0);
    put(8'h66, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_status_full", status, 8'hA4);
    wait_drain(600);
    chk("ovf_frames", stats.size(), 5);
    chk("ovf_sticky", ovf, 1);

    // Simultaneous write and pop on the STOP-final cycle
    gaps.delete(); stats.delete();
    put(8'h5A, 1);
    put(8'hC3, 1);
    repeat (39) @(negedge clk);
    put(8'h96, 1);
    chk("simul_status", status, 8'h21);
    wait_drain(600);
    chk("simul_frames", stats.size(), 3);
    if (stats.size() == 3) begin
      chk("simul_gap2", gaps[1], 0);
      chk("simul_gap3", gaps[2], 0);
      chk("simul_stat2", stats[1], 8'h21);
    end

    // Reset mid-frame during DATA bit 3 with 2 bytes queued
    put(8'hF0, 1);
    put(8'h0F, 1);
    put(8'hAA, 1);
    repeat (16) @(negedge clk);
    chk("prerst_txd", txd, 0);
    chk("prerst_count", status[4:0], 2);
    rst_bar = 1'b0;
    sb.delete();
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_status", status, 8'h40);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_bar = 1'b1;
    @(negedge clk);
    gaps.delete(); stats.delete();
    put(8'h3C, 1);
    wait_drain(200);
    chk("postrst_frames", stats.size(), 1);
    chk("postrst_status", status, 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
